// File: rtl/master_in_rx.sv
// master_in_rx: master-side bit-serial receive port with valid/ready handshake, bursts and output FIFO.
// Optional per-word even-parity check is enabled by defining MASTER_IN_PARITY_EN.
module master_in_rx #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned BURST_W    = 12,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter bit          LSB_FIRST  = 1'b1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          tx_done,
  input  logic [1:0]                    instruction,
  input  logic [BURST_W-1:0]            burst_num,
  input  logic                          slave_valid,
  input  logic                          rx_data,
  output logic                          master_ready,
  output logic                          rx_done,
  output logic                          busy,
  output logic                          out_valid,
  output logic [DATA_WIDTH-1:0]         out_data,
  input  logic                          out_ready,
`ifdef MASTER_IN_PARITY_EN
  output logic                          parity_err,
`endif
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

`ifdef MASTER_IN_PARITY_EN
  localparam int unsigned PAR_BITS = 1;
`else
  localparam int unsigned PAR_BITS = 0;
`endif
  localparam int unsigned RX_BITS = DATA_WIDTH + PAR_BITS;
  localparam int unsigned CNT_W   = $clog2(RX_BITS + 1);
  localparam int unsigned IDX_W   = $clog2(DATA_WIDTH);
  localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
  localparam int unsigned FCNT_W  = PTR_W + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_HANDSHAKE,
    S_RECEIVE
  } state_t;

  state_t                  state;
  logic [BURST_W-1:0]      words_left;
  logic [CNT_W-1:0]        bit_cnt;
  logic [DATA_WIDTH-1:0]   shift_reg;

  logic [CNT_W-1:0]        cur_bit;
  logic [IDX_W-1:0]        bit_pos;
  int unsigned             pos;
  logic [DATA_WIDTH-1:0]   data_next;
  logic                    last_bit;
  logic                    push;
  logic                    pop;

  logic [DATA_WIDTH-1:0]   mem [FIFO_DEPTH];
  logic [PTR_W-1:0]        wr_ptr;
  logic [PTR_W-1:0]        rd_ptr;
  logic [PTR_W-1:0]        rd_ptr_n;
  logic [FCNT_W-1:0]       count_n;

  // A slot is reserved at handshake, so a word in flight always has room.
  assign master_ready = (state == S_HANDSHAKE) && (32'(fifo_count) < FIFO_DEPTH);

  // Serial bit placement; the parity bit (index DATA_WIDTH) leaves the word untouched.
  always_comb begin
    cur_bit   = (state == S_RECEIVE) ? bit_cnt : '0;
    pos       = LSB_FIRST ? 32'(cur_bit) : (DATA_WIDTH - 1 - 32'(cur_bit));
    bit_pos   = IDX_W'(pos);
    data_next = shift_reg;
    if (32'(cur_bit) < DATA_WIDTH) begin
      data_next[bit_pos] = rx_data;
    end
    last_bit  = (state == S_RECEIVE) && (32'(bit_cnt) == RX_BITS - 1);
    push      = last_bit;
    pop       = out_valid && out_ready;
    count_n   = fifo_count + FCNT_W'(push) - FCNT_W'(pop);
    rd_ptr_n  = pop ? (rd_ptr + PTR_W'(1)) : rd_ptr;
  end

  // Transfer sequencing FSM.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      words_left <= '0;
      bit_cnt    <= '0;
      shift_reg  <= '0;
      rx_done    <= 1'b0;
      busy       <= 1'b0;
`ifdef MASTER_IN_PARITY_EN
      parity_err <= 1'b0;
`endif
    end else begin
      rx_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (tx_done && (instruction == 2'b11)) begin
            words_left <= burst_num;
            bit_cnt    <= '0;
            state      <= S_HANDSHAKE;
            busy       <= 1'b1;
`ifdef MASTER_IN_PARITY_EN
            parity_err <= 1'b0;
`endif
          end
        end
        S_HANDSHAKE: begin
          if (slave_valid && master_ready) begin
            shift_reg <= data_next;
            bit_cnt   <= CNT_W'(1);
            state     <= S_RECEIVE;
          end
        end
        S_RECEIVE: begin
          shift_reg <= data_next;
          bit_cnt   <= bit_cnt + CNT_W'(1);
          if (last_bit) begin
            bit_cnt <= '0;
`ifdef MASTER_IN_PARITY_EN
            if ((^shift_reg) ^ rx_data) begin
              parity_err <= 1'b1;
            end
`endif
            if (words_left == '0) begin
              state   <= S_IDLE;
              busy    <= 1'b0;
              rx_done <= 1'b1;
            end else begin
              words_left <= words_left - BURST_W'(1);
              state      <= S_HANDSHAKE;
            end
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // FIFO storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= data_next;
    end
  end

  // FIFO pointers, occupancy and registered head.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      rd_ptr     <= rd_ptr_n;
      fifo_count <= count_n;
      out_valid  <= (count_n != '0);
      if (push && ((fifo_count == '0) || ((fifo_count == FCNT_W'(1)) && pop))) begin
        out_data <= data_next;
      end else if (count_n != '0) begin
        out_data <= mem[rd_ptr_n];
      end
    end
  end

endmodule

// File: tb/tb_master_in_rx.sv
// Directed self-checking bench for master_in_rx (LSB-first main instance plus an MSB-first instance).
module tb_master_in_rx;

  localparam int unsigned DW = 8;
  localparam int unsigned BW = 12;
  localparam int unsigned FD = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          tx_done = 1'b0;
  logic          tx_done_m = 1'b0;
  logic [1:0]    instruction = 2'b00;
  logic [BW-1:0] burst_num = '0;
  logic          slave_valid = 1'b0;
  logic          rx_data = 1'b0;
  logic          out_ready = 1'b0;
  logic          out_ready_m = 1'b1;

  logic          master_ready, rx_done, busy, out_valid;
  logic [DW-1:0] out_data;
  logic [2:0]    fifo_count;
  logic          master_ready_m, rx_done_m, busy_m, out_valid_m;
  logic [DW-1:0] out_data_m;
  logic [2:0]    fifo_count_m;
`ifdef MASTER_IN_PARITY_EN
  logic          parity_err, parity_err_m;
  logic          par_bad = 1'b0;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  master_in_rx #(.DATA_WIDTH(DW), .BURST_W(BW), .FIFO_DEPTH(FD), .LSB_FIRST(1'b1)) dut (
    .clk(clk), .reset(reset), .tx_done(tx_done), .instruction(instruction),
    .burst_num(burst_num), .slave_valid(slave_valid), .rx_data(rx_data),
    .master_ready(master_ready), .rx_done(rx_done), .busy(busy),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
`ifdef MASTER_IN_PARITY_EN
    .parity_err(parity_err),
`endif
    .fifo_count(fifo_count)
  );

  master_in_rx #(.DATA_WIDTH(DW), .BURST_W(BW), .FIFO_DEPTH(FD), .LSB_FIRST(1'b0)) dut_m (
    .clk(clk), .reset(reset), .tx_done(tx_done_m), .instruction(instruction),
    .burst_num(burst_num), .slave_valid(slave_valid), .rx_data(rx_data),
    .master_ready(master_ready_m), .rx_done(rx_done_m), .busy(busy_m),
    .out_valid(out_valid_m), .out_data(out_data_m), .out_ready(out_ready_m),
`ifdef MASTER_IN_PARITY_EN
    .parity_err(parity_err_m),
`endif
    .fifo_count(fifo_count_m)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start(input logic [BW-1:0] b, input logic both);
    instruction = 2'b11;
    burst_num   = b;
    tx_done     = 1'b1;
    tx_done_m   = both;
    @(negedge clk);
    tx_done     = 1'b0;
    tx_done_m   = 1'b0;
    instruction = 2'b00;
  endtask

  // s[k] is the k-th serial bit; returns at the negedge after the last capture edge.
  task automatic send_word(input logic [7:0] s);
    int guard;
    guard       = 0;
    slave_valid = 1'b1;
    rx_data     = s[0];
    while (!master_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) check("hs_timeout", 32'(master_ready), 32'd1);
    @(negedge clk);
    slave_valid = 1'b0;
    for (int k = 1; k < 8; k++) begin
      rx_data = s[k];
      @(negedge clk);
    end
`ifdef MASTER_IN_PARITY_EN
    rx_data = (^s) ^ par_bad;
    @(negedge clk);
`endif
    rx_data = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 reset = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_fifo_count", 32'(fifo_count), 32'd0);
    check("rst_master_ready", 32'(master_ready), 32'd0);
    check("rst_rx_done", 32'(rx_done), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Non-read instruction must not start.
    instruction = 2'b10; tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0; instruction = 2'b00;
    check("nonread_busy", 32'(busy), 32'd0);
    check("nonread_ready", 32'(master_ready), 32'd0);

    // Single read, serial 1,0,1,0,0,1,0,1 -> A5.
    start(12'd0, 1'b0);
    check("single_busy", 32'(busy), 32'd1);
    check("single_ready", 32'(master_ready), 32'd1);
    send_word(8'hA5);
    check("single_data", 32'(out_data), 32'hA5);
    check("single_valid", 32'(out_valid), 32'd1);
    check("single_rx_done", 32'(rx_done), 32'd1);
    check("single_count", 32'(fifo_count), 32'd1);
    check("single_idle", 32'(busy), 32'd0);
    @(negedge clk);
    check("single_rx_done_pulse", 32'(rx_done), 32'd0);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("single_pop_count", 32'(fifo_count), 32'd0);
    check("single_pop_valid", 32'(out_valid), 32'd0);

    // Burst of three with continuous pop.
    out_ready = 1'b1;
    start(12'd2, 1'b0);
    send_word(8'h11);
    check("burst_w0", 32'(out_data), 32'h11);
    check("burst_w0_done", 32'(rx_done), 32'd0);
    check("burst_w0_busy", 32'(busy), 32'd1);
    send_word(8'h22);
    check("burst_w1", 32'(out_data), 32'h22);
    check("burst_w1_done", 32'(rx_done), 32'd0);
    send_word(8'h33);
    check("burst_w2", 32'(out_data), 32'h33);
    check("burst_w2_done", 32'(rx_done), 32'd1);
    check("burst_w2_busy", 32'(busy), 32'd0);
    @(negedge clk);
    check("burst_done_pulse", 32'(rx_done), 32'd0);
    check("burst_drained", 32'(fifo_count), 32'd0);
    out_ready = 1'b0;

    // Back-pressure: six words into a four-entry FIFO.
    start(12'd5, 1'b0);
    send_word(8'h40);
    send_word(8'h41);
    send_word(8'h42);
    send_word(8'h43);
    check("bp_full_count", 32'(fifo_count), 32'd4);
    check("bp_head", 32'(out_data), 32'h40);
    check("bp_ready_low", 32'(master_ready), 32'd0);
    repeat (3) @(negedge clk);
    check("bp_ready_still_low", 32'(master_ready), 32'd0);
    check("bp_busy", 32'(busy), 32'd1);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("bp_ready_after_pop", 32'(master_ready), 32'd1);
    check("bp_count_after_pop", 32'(fifo_count), 32'd3);
    check("bp_head_after_pop", 32'(out_data), 32'h41);
    send_word(8'h44);
    check("bp_refill_count", 32'(fifo_count), 32'd4);
    check("bp_refill_head", 32'(out_data), 32'h41);
    out_ready = 1'b1;
    send_word(8'h45);
    check("bp_last_data", 32'(out_data), 32'h45);
    check("bp_last_count", 32'(fifo_count), 32'd1);
    check("bp_last_done", 32'(rx_done), 32'd1);
    @(negedge clk);
    out_ready = 1'b0;
    check("bp_drained", 32'(fifo_count), 32'd0);

    // Bit order: serial 1,1,0,0,0,0,0,0 -> 03 LSB-first, C0 MSB-first.
    start(12'd0, 1'b1);
    send_word(8'b0000_0011);
    check("order_lsb", 32'(out_data), 32'h03);
    check("order_msb", 32'(out_data_m), 32'hC0);
    check("order_msb_done", 32'(rx_done_m), 32'd1);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    start(12'd0, 1'b1);
    send_word(8'hA5);
    check("order_lsb_a5", 32'(out_data), 32'hA5);
    check("order_msb_a5", 32'(out_data_m), 32'hA5);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;

    // Reset during bit 4 of the second burst word.
    start(12'd2, 1'b0);
    send_word(8'h77);
    check("abort_w0_count", 32'(fifo_count), 32'd1);
    slave_valid = 1'b1; rx_data = 1'b1;
    check("abort_ready", 32'(master_ready), 32'd1);
    @(negedge clk);
    slave_valid = 1'b0;
    for (int k = 1; k < 4; k++) begin
      rx_data = k[0];
      @(negedge clk);
    end
    #2 reset = 1'b1;
    #1;
    check("abort_count", 32'(fifo_count), 32'd0);
    check("abort_valid", 32'(out_valid), 32'd0);
    check("abort_data", 32'(out_data), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_ready_low", 32'(master_ready), 32'd0);
    check("abort_rx_done", 32'(rx_done), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    rx_data = 1'b0;
    @(negedge clk);
    start(12'd0, 1'b0);
    send_word(8'h5A);
    check("post_abort_data", 32'(out_data), 32'h5A);
    check("post_abort_count", 32'(fifo_count), 32'd1);
    check("post_abort_done", 32'(rx_done), 32'd1);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;

`ifdef MASTER_IN_PARITY_EN
    // Good parity, then bad parity (sticky until the next start).
    par_bad = 1'b0;
    start(12'd0, 1'b0);
    send_word(8'hA5);
    check("par_good", 32'(parity_err), 32'd0);
    check("par_good_data", 32'(out_data), 32'hA5);
    par_bad = 1'b1;
    start(12'd0, 1'b0);
    send_word(8'hA5);
    check("par_bad", 32'(parity_err), 32'd1);
    check("par_bad_pushed", 32'(fifo_count), 32'd2);
    repeat (3) @(negedge clk);
    check("par_sticky", 32'(parity_err), 32'd1);
    par_bad = 1'b0;
    start(12'd0, 1'b0);
    check("par_clear_on_start", 32'(parity_err), 32'd0);
    send_word(8'h3C);
    check("par_clear_stays", 32'(parity_err), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/master_in_rx.md
Name: master_in_rx

Overview:
Parametrised master-side receive port for the system bus. It deserialises bit-serial read data from a slave under a valid/ready handshake and collects single or burst transfers. Completed words go into a small output FIFO that drives the display/consumer side. FIFO occupancy back-pressures the slave.

Parameters:
DATA_WIDTH, 8, bits per word; >= 2
BURST_W, 12, width of burst_num
FIFO_DEPTH, 4, output FIFO entries; power of two, >= 2
LSB_FIRST, 1, 1: first serial bit is word bit 0; 0: first serial bit is word bit DATA_WIDTH-1

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-high reset
tx_done  in  1  master-out transaction finished; start qualifier
instruction  in  2  bus instruction; 2'b11 = read
burst_num  in  BURST_W  words to receive minus 1; sampled at start
slave_valid  in  1  slave presents first bit of a word
rx_data  in  1  serial data from slave
master_ready  out  1  master can accept a word
rx_done  out  1  one-cycle pulse, transfer complete
busy  out  1  high whenever state != IDLE
out_valid  out  1  FIFO non-empty
out_data  out  DATA_WIDTH  FIFO head word
out_ready  in  1  consumer pops head when out_valid && out_ready
fifo_count  out  clog2(FIFO_DEPTH)+1  FIFO occupancy

Behaviour:
- Reset (async, immediate): state=IDLE, master_ready=0, rx_done=0, busy=0, out_valid=0, out_data=0, fifo_count=0. Shift register, bit counter and word counter cleared. FIFO contents discarded. A reset during a transfer aborts it; no partial word is pushed.
- IDLE: master_ready=0. If tx_done && instruction==2'b11, latch burst_num into words_left, clear the word counter, go to HANDSHAKE. Any other combination stays in IDLE.
- HANDSHAKE: master_ready = (fifo_count < FIFO_DEPTH), driven combinationally from the registered count.
  - If slave_valid && master_ready: capture rx_data as serial bit 0, set bit_cnt=1, go to RECEIVE.
  - Otherwise stay in HANDSHAKE; rx_data is ignored.
- RECEIVE: master_ready=0. Capture rx_data every cycle with no further handshake. slave_valid is ignored.
  - On the capture where bit_cnt==DATA_WIDTH-1, push the complete word, including this final bit, into the FIFO in the same edge.
  - If words_left==0, go to IDLE and assert rx_done on the next cycle for exactly 1 cycle. Otherwise decrement words_left and go to HANDSHAKE.
- Bit mapping: serial bit k goes to word bit k (LSB_FIRST=1) or to DATA_WIDTH-1-k (LSB_FIRST=0).
- Latency: the last bit of a word is sampled at edge N. The word appears at out_data/out_valid after edge N if the FIFO was empty (1 cycle). rx_done is high between edges N and N+1 for the final word.
- Transfer length: burst_num=0 gives 1 word; burst_num=B gives B+1 words. Maximum is 2^BURST_W words.
- FIFO: synchronous, registered head.
  - Push and pop in the same cycle: count unchanged, order preserved.
  - Pop when empty is ignored.
  - Push when full cannot occur, because a slot is reserved at handshake and only pops occur while a word is in flight.
  - Read and write pointers wrap modulo FIFO_DEPTH.
- Back-pressure: while the FIFO is full, master_ready stays low in HANDSHAKE indefinitely. It rises in the cycle after a pop.
- tx_done/instruction are ignored outside IDLE. A new start in the same cycle that rx_done is high is accepted, because the FSM is already in IDLE.

Optional Feature:
Macro MASTER_IN_PARITY_EN.
- Defined:
  - The slave sends 1 extra even-parity bit after each word; the word occupies DATA_WIDTH+1 RECEIVE bits.
  - The push and completion decision happen on the parity-bit capture.
  - Adds output parity_err (1 bit). It is sticky-high on any word whose XOR of data bits and parity bit is 1.
  - parity_err clears on reset or on a new start from IDLE. The word is pushed regardless.
- Undefined: no parity bit, no parity_err port; timing as above.

Test Plan:
- Single read, DATA_WIDTH=8, LSB_FIRST=1, burst_num=0. Serial bits 1,0,1,0,0,1,0,1 -> out_data=8'hA5 one cycle after the 8th bit; rx_done pulses 1 cycle; fifo_count=1.
- Burst burst_num=2, words 8'h11,8'h22,8'h33, out_ready=1 -> three handshakes. Outputs popped in order 11,22,33. Exactly one rx_done, after 8'h33.
- Back-pressure, FIFO_DEPTH=4, out_ready=0, burst_num=5 -> after 4 words master_ready stays 0 and fifo_count=4. Raising out_ready for 1 cycle pops 1 word; master_ready=1 the next cycle; the 5th word is accepted.
- LSB_FIRST=0, bits 1,0,1,0,0,1,0,1 -> out_data=8'hA5 (MSB first). The same bits with LSB_FIRST=1 give 8'hA5 reversed = 8'hA5. Use 1,1,0,0,0,0,0,0 to distinguish: 8'h03 vs 8'hC0.
- Reset asserted at bit 4 of word 2 of a burst -> all outputs at reset values immediately; fifo_count=0. A following start with instruction=2'b11 runs normally.
- MASTER_IN_PARITY_EN: word 8'hA5 with parity 0 -> parity_err=0. Word 8'hA5 with parity 1 -> parity_err=1, the word is still pushed, and parity_err stays high until the next start.
